// File: rtl/long_fifo_sync_if.sv
// Stream-side bundle of the long_fifo_sync FIFO: write port, read port, flush and status.
// The master modport is the environment that drives the FIFO; the slave modport is the FIFO itself.
interface long_fifo_sync_if #(
  parameter int DSIZE = 8,
  parameter int DEPTH = 12000
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clear;
  logic [DSIZE-1:0] din;
  logic             wr_en;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [DSIZE-1:0] dout;
  logic             empty;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, din, wr_en, rd_en,
    input  full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, din, wr_en, rd_en,
    output full, almost_full, dout, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/long_fifo_sync.sv
// Single-clock FIFO of arbitrary depth with fill count, threshold flags, sticky error flags,
// synchronous flush and a choice of first-word-fall-through or standard read timing.
module long_fifo_sync #(
  parameter int DSIZE    = 8,
  parameter int DEPTH    = 12000,
  parameter int FWFT     = 1,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  long_fifo_sync_if.slave bus
);
  // In FWFT mode the visible output register is one of the DEPTH slots.
  localparam int RAM_D = (FWFT != 0) ? DEPTH - 1 : DEPTH;
  localparam int PW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;
  localparam logic [PW-1:0] LAST = PW'(RAM_D - 1);

  logic [DSIZE-1:0] r_mem [RAM_D];
  logic [DSIZE-1:0] r_ram_q;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_full;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_udf;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_ram_we;
  logic             w_ram_re;
  logic [DSIZE-1:0] w_dout;

  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign w_wr_acc = bus.wr_en & ~r_full;
  assign w_rd_acc = bus.rd_en & ~w_empty;
  assign w_ram_we = w_wr_acc & ~bus.clear;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_wptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_ram_q <= {DSIZE{1'b0}};
    end else if (bus.clear) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_ram_q <= {DSIZE{1'b0}};
    end else begin
      if (w_ram_we) begin
        r_wptr <= f_next_ptr(r_wptr);
      end
      if (w_ram_re) begin
        r_rptr  <= f_next_ptr(r_rptr);
        r_ram_q <= r_mem[r_rptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CW{1'b0}};
      r_full  <= 1'b0;
      r_af    <= (AF_LEVEL <= 0);
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (bus.clear) begin
      r_count <= {CW{1'b0}};
      r_full  <= 1'b0;
      r_af    <= (AF_LEVEL <= 0);
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_af    <= (int'(w_cnt_nxt) >= AF_LEVEL);
      r_ae    <= (int'(w_cnt_nxt) <= AE_LEVEL);
      r_ovf   <= r_ovf | (bus.wr_en & r_full);
      r_udf   <= r_udf | (bus.rd_en & w_empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic [CW-1:0]    r_ram_cnt;
      logic             r_pend;
      logic             r_ovalid;
      logic [DSIZE-1:0] r_dout;
      logic             w_pend_adv;

      // r_ram_q is a staging slot: it refills in the same cycle it hands its word to dout,
      // which keeps back-to-back reads bubble-free.
      assign w_pend_adv = r_pend & (~r_ovalid | w_rd_acc);
      assign w_ram_re   = (r_ram_cnt != CW'(0)) & (~r_pend | w_pend_adv) & ~bus.clear;
      assign w_empty    = ~r_ovalid;
      assign w_dout     = r_dout;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ram_cnt <= {CW{1'b0}};
          r_pend    <= 1'b0;
          r_ovalid  <= 1'b0;
          r_dout    <= {DSIZE{1'b0}};
        end else if (bus.clear) begin
          r_ram_cnt <= {CW{1'b0}};
          r_pend    <= 1'b0;
          r_ovalid  <= 1'b0;
          r_dout    <= {DSIZE{1'b0}};
        end else begin
          case ({w_ram_we, w_ram_re})
            2'b10:   r_ram_cnt <= r_ram_cnt + CW'(1);
            2'b01:   r_ram_cnt <= r_ram_cnt - CW'(1);
            default: r_ram_cnt <= r_ram_cnt;
          endcase
          if (w_ram_re) begin
            r_pend <= 1'b1;
          end else if (w_pend_adv) begin
            r_pend <= 1'b0;
          end
          if (w_pend_adv) begin
            r_dout   <= r_ram_q;
            r_ovalid <= 1'b1;
          end else if (w_rd_acc) begin
            r_ovalid <= 1'b0;
          end
        end
      end
    end else begin : g_std
      logic r_empty;

      assign w_ram_re = w_rd_acc & ~bus.clear;
      assign w_empty  = r_empty;
      assign w_dout   = r_ram_q;

      // Empty asserts with the count reaching zero but releases one cycle after the first write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_empty <= 1'b1;
        end else if (bus.clear) begin
          r_empty <= 1'b1;
        end else begin
          r_empty <= (w_cnt_nxt == CW'(0)) | (r_count == CW'(0));
        end
      end
    end
  endgenerate

  assign bus.full         = r_full;
  assign bus.almost_full  = r_af;
  assign bus.empty        = w_empty;
  assign bus.almost_empty = r_ae;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;
  assign bus.dout         = w_dout;
endmodule

// File: tb/tb_long_fifo_sync.sv
// Scoreboard bench for long_fifo_sync: an FWFT instance (DEPTH=5, AF=4, AE=1) and a standard-mode instance.
module tb_long_fifo_sync;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   idx;
  bit   b_pend = 1'b0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  long_fifo_sync_if #(.DSIZE(8), .DEPTH(5)) a_if ();
  long_fifo_sync_if #(.DSIZE(8), .DEPTH(5)) b_if ();

  long_fifo_sync #(.DSIZE(8), .DEPTH(5), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );
  long_fifo_sync #(.DSIZE(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_a();
    chk("a_rst_count", 32'(a_if.count), 32'd0);
    chk("a_rst_empty", 32'(a_if.empty), 32'd1);
    chk("a_rst_ae", 32'(a_if.almost_empty), 32'd1);
    chk("a_rst_full", 32'(a_if.full), 32'd0);
    chk("a_rst_af", 32'(a_if.almost_full), 32'd0);
    chk("a_rst_ovf", 32'(a_if.overflow), 32'd0);
    chk("a_rst_udf", 32'(a_if.underflow), 32'd0);
    chk("a_rst_dout", 32'(a_if.dout), 32'd0);
  endtask

  task automatic chk_rst_b();
    chk("b_rst_count", 32'(b_if.count), 32'd0);
    chk("b_rst_empty", 32'(b_if.empty), 32'd1);
    chk("b_rst_dout", 32'(b_if.dout), 32'd0);
  endtask

  // FWFT monitor: dout must already hold the word when a read is about to be accepted.
  always @(negedge clk) begin
    if (rst_n && a_if.rd_en && !a_if.empty) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_read: got %0h expected no word", a_if.dout);
      end else begin
        chk("a_dout", 32'(a_if.dout), 32'(qa.pop_front()));
      end
    end
  end

  // Standard-mode monitor: dout is checked one cycle after the accepting edge.
  always @(negedge clk) begin
    if (b_pend) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_read: got %0h expected no word", b_if.dout);
      end else begin
        chk("b_dout", 32'(b_if.dout), 32'(qb.pop_front()));
      end
    end
    b_pend = rst_n && b_if.rd_en && !b_if.empty;
  end

  initial begin
    a_if.clear = 1'b0; a_if.din = 8'h00; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
    b_if.clear = 1'b0; b_if.din = 8'h00; b_if.wr_en = 1'b0; b_if.rd_en = 1'b0;
    step();
    step();
    chk_rst_a();
    chk_rst_b();
    rst_n = 1'b1;
    step();

    // Fill to full while tracking the threshold flags.
    for (int i = 0; i < 5; i++) begin
      a_if.wr_en = 1'b1;
      a_if.din   = 8'(8'h10 + i);
      qa.push_back(a_if.din);
      step();
      chk("a_fill_count", 32'(a_if.count), 32'(i + 1));
      chk("a_fill_af", 32'(a_if.almost_full), 32'((i + 1) >= 4));
      chk("a_fill_ae", 32'(a_if.almost_empty), 32'((i + 1) <= 1));
    end
    chk("a_full", 32'(a_if.full), 32'd1);
    a_if.din = 8'h15;
    step();
    a_if.wr_en = 1'b0;
    chk("a_ovf", 32'(a_if.overflow), 32'd1);
    chk("a_ovf_count", 32'(a_if.count), 32'd5);

    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < 8 && a_if.empty; w++) step();
      chk("a_drain_ready", 32'(a_if.empty), 32'd0);
      a_if.rd_en = 1'b1;
      step();
      a_if.rd_en = 1'b0;
      chk("a_drain_count", 32'(a_if.count), 32'(4 - i));
    end
    step(); step(); step();
    chk("a_drained_empty", 32'(a_if.empty), 32'd1);
    chk("a_drained_ae", 32'(a_if.almost_empty), 32'd1);
    a_if.rd_en = 1'b1;
    step();
    a_if.rd_en = 1'b0;
    chk("a_udf", 32'(a_if.underflow), 32'd1);

    // Flush with a concurrent write: the write is discarded and the sticky flags drop.
    for (int i = 0; i < 3; i++) begin
      a_if.wr_en = 1'b1;
      a_if.din   = 8'(8'h30 + i);
      step();
    end
    chk("a_pre_clear_count", 32'(a_if.count), 32'd3);
    a_if.clear = 1'b1;
    a_if.din   = 8'h33;
    step();
    a_if.clear = 1'b0;
    a_if.wr_en = 1'b0;
    chk("a_clr_count", 32'(a_if.count), 32'd0);
    chk("a_clr_empty", 32'(a_if.empty), 32'd1);
    chk("a_clr_ovf", 32'(a_if.overflow), 32'd0);
    chk("a_clr_udf", 32'(a_if.underflow), 32'd0);
    step(); step(); step();
    chk("a_clr_still_empty", 32'(a_if.empty), 32'd1);
    chk("a_clr_still_zero", 32'(a_if.count), 32'd0);

    // FWFT latency: visible two edges after the write.
    a_if.wr_en = 1'b1;
    a_if.din   = 8'hA5;
    qa.push_back(8'hA5);
    step();
    a_if.wr_en = 1'b0;
    chk("a_lat_n", 32'(a_if.empty), 32'd1);
    step();
    chk("a_lat_n1", 32'(a_if.empty), 32'd1);
    step();
    chk("a_lat_n2_empty", 32'(a_if.empty), 32'd0);
    chk("a_lat_n2_dout", 32'(a_if.dout), 32'hA5);
    a_if.rd_en = 1'b1;
    step();
    a_if.rd_en = 1'b0;
    step();
    chk("a_lat_consumed", 32'(a_if.empty), 32'd1);

    // Streaming through the non-power-of-two depth with both enables high.
    idx = 0;
    a_if.rd_en = 1'b1;
    for (int c = 0; c < 60 && (idx < 23 || qa.size() != 0); c++) begin
      if (idx < 23) begin
        a_if.wr_en = 1'b1;
        a_if.din   = 8'(8'h40 + idx);
        if (!a_if.full) begin
          qa.push_back(a_if.din);
          idx++;
        end
      end else begin
        a_if.wr_en = 1'b0;
      end
      step();
      chk("a_wrap_count_range", 32'(a_if.count <= 3'd5), 32'd1);
    end
    a_if.rd_en = 1'b0;
    a_if.wr_en = 1'b0;
    chk("a_wrap_drained", 32'(qa.size()), 32'd0);
    step();
    chk("a_wrap_count_end", 32'(a_if.count), 32'd0);

    // Standard mode latency and read path.
    b_if.wr_en = 1'b1;
    b_if.din   = 8'hA5;
    qb.push_back(8'hA5);
    step();
    b_if.wr_en = 1'b0;
    chk("b_lat_n_empty", 32'(b_if.empty), 32'd1);
    chk("b_lat_n_count", 32'(b_if.count), 32'd1);
    step();
    chk("b_lat_n1_empty", 32'(b_if.empty), 32'd0);
    chk("b_dout_before_read", 32'(b_if.dout), 32'd0);
    b_if.wr_en = 1'b1;
    b_if.din   = 8'h5A;
    qb.push_back(8'h5A);
    step();
    b_if.din   = 8'h3C;
    qb.push_back(8'h3C);
    step();
    b_if.wr_en = 1'b0;
    chk("b_count3", 32'(b_if.count), 32'd3);
    b_if.rd_en = 1'b1;
    step(); step(); step();
    b_if.rd_en = 1'b0;
    step();
    chk("b_end_empty", 32'(b_if.empty), 32'd1);
    chk("b_end_count", 32'(b_if.count), 32'd0);
    chk("b_dout_hold", 32'(b_if.dout), 32'h3C);
    chk("b_drained", 32'(qb.size()), 32'd0);

    // Asynchronous reset in the middle of traffic, checked before the next clock edge.
    a_if.wr_en = 1'b1;
    a_if.din   = 8'h77;
    a_if.rd_en = 1'b1;
    a_if.rd_en = 1'b0;
    step();
    step();
    chk("a_mid_count", 32'(a_if.count), 32'd2);
    a_if.rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    a_if.rd_en = 1'b0;
    chk_rst_a();
    chk_rst_b();
    a_if.wr_en = 1'b0;
    qa.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("a_post_rst_empty", 32'(a_if.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
